// File: rtl/ls1u_int_ctrl.sv
// ls1u_int_ctrl: 8-line prioritised interrupt controller for KC_LS1u_plus, configured over the XCR bus.
// Optional build macro LS1U_INTC_SWI_EN enables software interrupt set (offset 6) on edge lines 0-3.
module ls1u_int_ctrl #(
  parameter logic [7:0]  XCR_BASE  = 8'h10,
  parameter int unsigned VEC_SHIFT = 4,
  parameter logic [23:0] VBASE_RST = 24'h000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq_i,
  input  logic [7:0]  xcr_a,
  input  logic [7:0]  xcr_wdata,
  input  logic        xcr_we,
  input  logic        xcr_cs,
  output logic [7:0]  xcr_rdata,
  output logic        int_o,
  output logic [23:0] ivec_addr_o,
  input  logic        in_isp_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_e;

  // Lines 0-3 are edge-triggered, 4-7 follow their input level.
  localparam logic [7:0] EDGE_MASK = 8'h0F;

  state_e      state_q, state_d;
  logic [7:0]  ie_q, ie_d;
  logic [7:0]  ip_q, ip_d;
  logic [7:0]  irq_dly_q;
  logic [23:0] vbase_q, vbase_d;
  logic [23:0] ivec_q, ivec_d;
  logic        gen_q, gen_d;
  logic        int_q, int_d;
  logic [2:0]  id_q, id_d;

  logic        hit, wr;
  logic [2:0]  off;
  logic [7:0]  req, edge_set, swi_set, w1c_clr, ack_clr;
  logic [2:0]  win_id;

  always_comb begin
    hit = xcr_cs && (xcr_a[7:3] == XCR_BASE[7:3]);
    wr  = hit && xcr_we;
    off = xcr_a[2:0];
  end

  always_comb begin
    req    = ip_q & ie_q;
    win_id = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) win_id = 3'(i);
    end
  end

  // State register; irq delay runs free so edges are judged against the true previous input.
  always_ff @(posedge clk) begin
    irq_dly_q <= irq_i;
    if (rst) begin
      state_q <= S_IDLE;
      ie_q    <= '0;
      ip_q    <= '0;
      vbase_q <= VBASE_RST;
      gen_q   <= 1'b0;
      id_q    <= '0;
      int_q   <= 1'b0;
      ivec_q  <= VBASE_RST;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      vbase_q <= vbase_d;
      gen_q   <= gen_d;
      id_q    <= id_d;
      int_q   <= int_d;
      ivec_q  <= ivec_d;
    end
  end

  // Next state: id and vector are captured once at arbitration and frozen until the service ends.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    int_d   = int_q;
    ivec_d  = ivec_q;
    ack_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (gen_q && (|req)) begin
          id_d    = win_id;
          ivec_d  = vbase_q + (24'(win_id) << VEC_SHIFT);
          int_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (in_isp_i) begin
          int_d   = 1'b0;
          ack_clr = (8'b1 << id_q) & EDGE_MASK;
          state_d = S_SVC;
        end
      end
      S_SVC: begin
        int_d = 1'b0;
        if (!in_isp_i) begin
          id_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        int_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ie_d     = ie_q;
    vbase_d  = vbase_q;
    gen_d    = gen_q;
    edge_set = irq_i & ~irq_dly_q & EDGE_MASK;
    w1c_clr  = (wr && (off == 3'd1)) ? xcr_wdata : 8'h00;
`ifdef LS1U_INTC_SWI_EN
    swi_set  = (wr && (off == 3'd6)) ? {4'b0000, xcr_wdata[3:0]} : 8'h00;
`else
    swi_set  = 8'h00;
`endif
    // Set sources win over any clear landing in the same cycle.
    ip_d = (((ip_q & ~w1c_clr & ~ack_clr) | edge_set | swi_set) & EDGE_MASK) |
           (irq_i & ~EDGE_MASK);
    if (wr) begin
      case (off)
        3'd0: ie_d           = xcr_wdata;
        3'd2: vbase_d[7:0]   = xcr_wdata;
        3'd3: vbase_d[15:8]  = xcr_wdata;
        3'd4: vbase_d[23:16] = xcr_wdata;
        3'd7: gen_d          = xcr_wdata[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    int_o       = int_q;
    ivec_addr_o = ivec_q;
    xcr_rdata   = 8'h00;
    if (hit && !xcr_we) begin
      case (off)
        3'd0: xcr_rdata = ie_q;
        3'd1: xcr_rdata = ip_q;
        3'd2: xcr_rdata = vbase_q[7:0];
        3'd3: xcr_rdata = vbase_q[15:8];
        3'd4: xcr_rdata = vbase_q[23:16];
        3'd5: xcr_rdata = {(state_q != S_IDLE), 4'b0000, id_q};
        3'd7: xcr_rdata = {7'b0000000, gen_q};
        default: xcr_rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_ls1u_int_ctrl.sv
// Bench for ls1u_int_ctrl: directed vector table, hand sequences, then randomized traffic vs a reference model.
module tb_ls1u_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_i, xcr_a, xcr_wdata, xcr_rdata;
  logic        xcr_we, xcr_cs, int_o, in_isp_i;
  logic [23:0] ivec_addr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ls1u_int_ctrl dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .xcr_a(xcr_a), .xcr_wdata(xcr_wdata),
    .xcr_we(xcr_we), .xcr_cs(xcr_cs), .xcr_rdata(xcr_rdata), .int_o(int_o),
    .ivec_addr_o(ivec_addr_o), .in_isp_i(in_isp_i)
  );

  typedef struct {
    logic [7:0]  irq;
    logic        isp;
    logic        we;
    logic [7:0]  a;
    logic [7:0]  wd;
    logic        eint;
    logic [23:0] eivec;
    logic [7:0]  erd;
  } vec_t;

  vec_t tbl[$];

  // Reference model: 0 = idle, 1 = requesting, 2 = in service
  int         m_state, m_id;
  bit         m_int, m_gen;
  bit [7:0]   m_ie, m_ip, m_irqd;
  bit [23:0]  m_vb, m_ivec;

  function automatic void model_reset();
    m_state = 0; m_id = 0; m_int = 0; m_gen = 0;
    m_ie = 0; m_ip = 0; m_vb = 24'h000100; m_ivec = 24'h000100;
  endfunction

  function automatic void model_step();
    bit [7:0] nip;
    bit [3:0] swi;
    int nstate, nid, ack, off;
    bit nint, wr, setb, clrb;
    bit [23:0] nivec;
    if (rst) begin
      model_reset();
      m_irqd = irq_i;
      return;
    end
    nstate = m_state; nid = m_id; nint = m_int; nivec = m_ivec; ack = -1; swi = 0;
    wr  = xcr_cs && xcr_we && (xcr_a >= 8'h10) && (xcr_a <= 8'h17);
    off = int'(xcr_a) - 16;
    if (m_state == 0) begin
      if (m_gen && ((m_ip & m_ie) != 0)) begin
        for (int k = 7; k >= 0; k--) if (m_ip[k] && m_ie[k]) nid = k;
        nivec  = 24'(int'(m_vb) + nid * 16);
        nint   = 1;
        nstate = 1;
      end
    end else if (m_state == 1) begin
      if (in_isp_i) begin nint = 0; ack = m_id; nstate = 2; end
    end else begin
      if (!in_isp_i) begin nstate = 0; nid = 0; end
    end
`ifdef LS1U_INTC_SWI_EN
    if (wr && off == 6) swi = xcr_wdata[3:0];
`endif
    for (int n = 0; n < 8; n++) begin
      if (n >= 4) nip[n] = irq_i[n];
      else begin
        setb = (irq_i[n] && !m_irqd[n]) || swi[n];
        clrb = (wr && off == 1 && xcr_wdata[n]) || (ack == n);
        nip[n] = setb ? 1'b1 : (clrb ? 1'b0 : m_ip[n]);
      end
    end
    if (wr) begin
      case (off)
        0: m_ie = xcr_wdata;
        2: m_vb[7:0] = xcr_wdata;
        3: m_vb[15:8] = xcr_wdata;
        4: m_vb[23:16] = xcr_wdata;
        7: m_gen = xcr_wdata[0];
        default: ;
      endcase
    end
    m_ip = nip; m_state = nstate; m_id = nid; m_int = nint; m_ivec = nivec; m_irqd = irq_i;
  endfunction

  function automatic logic [7:0] model_read();
    if (!(xcr_cs && !xcr_we && xcr_a >= 8'h10 && xcr_a <= 8'h17)) return 8'h00;
    case (int'(xcr_a) - 16)
      0: return m_ie;
      1: return m_ip;
      2: return m_vb[7:0];
      3: return m_vb[15:8];
      4: return m_vb[23:16];
      5: return {(m_state != 0), 4'b0000, 3'(m_id)};
      7: return {7'b0000000, m_gen};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic [7:0] irq, input logic isp, input logic we,
                     input logic [7:0] a, input logic [7:0] wd);
    irq_i = irq; in_isp_i = isp; xcr_we = we; xcr_a = a; xcr_wdata = wd; xcr_cs = 1'b1;
    tick();
  endtask

  task automatic add_w(input logic [7:0] a, input logic [7:0] wd, input logic [7:0] irq,
                       input logic eint, input logic [23:0] eivec);
    vec_t v;
    v = '{irq, 1'b0, 1'b1, a, wd, eint, eivec, 8'h00};
    tbl.push_back(v);
  endtask

  task automatic add_r(input logic [7:0] a, input logic [7:0] irq, input logic isp,
                       input logic eint, input logic [23:0] eivec, input logic [7:0] erd);
    vec_t v;
    v = '{irq, isp, 1'b0, a, 8'h00, eint, eivec, erd};
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] swi_ip;
    int sel;
    rst = 1'b1; irq_i = '0; xcr_a = '0; xcr_wdata = '0; xcr_we = 1'b0; xcr_cs = 1'b0; in_isp_i = 1'b0;
    model_reset();
    m_irqd = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_int", int_o, 1'b0);
    chk("rst_ivec", ivec_addr_o, 24'h000100);
    cyc(8'h00, 0, 0, 8'h10, 8'h00); chk("rst_ie", xcr_rdata, 8'h00);
    cyc(8'h00, 0, 0, 8'h11, 8'h00); chk("rst_ip", xcr_rdata, 8'h00);
    cyc(8'h00, 0, 0, 8'h13, 8'h00); chk("rst_vb1", xcr_rdata, 8'h01);
    cyc(8'h00, 0, 0, 8'h15, 8'h00); chk("rst_cur", xcr_rdata, 8'h00);
    cyc(8'h00, 0, 0, 8'h17, 8'h00); chk("rst_ctrl", xcr_rdata, 8'h00);

`ifdef LS1U_INTC_SWI_EN
    swi_ip = 8'h01;
`else
    swi_ip = 8'h00;
`endif

    // basic edge request on line 0
    add_w(8'h10, 8'h01, 8'h00, 0, 24'h000100);
    add_w(8'h17, 8'h01, 8'h00, 0, 24'h000100);
    add_r(8'h11, 8'h01, 0, 0, 24'h000100, 8'h01);
    add_r(8'h11, 8'h00, 0, 1, 24'h000100, 8'h01);
    add_r(8'h15, 8'h00, 0, 1, 24'h000100, 8'h80);
    add_r(8'h11, 8'h00, 1, 0, 24'h000100, 8'h00);
    add_r(8'h15, 8'h00, 1, 0, 24'h000100, 8'h80);
    add_r(8'h15, 8'h00, 0, 0, 24'h000100, 8'h00);
    // priority between lines 2 and 3, new vector base
    add_w(8'h12, 8'h00, 8'h00, 0, 24'h000100);
    add_w(8'h13, 8'h23, 8'h00, 0, 24'h000100);
    add_w(8'h14, 8'h01, 8'h00, 0, 24'h000100);
    add_w(8'h10, 8'h0C, 8'h00, 0, 24'h000100);
    add_r(8'h11, 8'h0C, 0, 0, 24'h000100, 8'h0C);
    add_r(8'h15, 8'h00, 0, 1, 24'h012320, 8'h82);
    add_r(8'h11, 8'h00, 1, 0, 24'h012320, 8'h08);
    add_r(8'h15, 8'h00, 0, 0, 24'h012320, 8'h00);
    add_r(8'h15, 8'h00, 0, 1, 24'h012330, 8'h83);
    add_r(8'h11, 8'h00, 1, 0, 24'h012330, 8'h00);
    add_r(8'h15, 8'h00, 0, 0, 24'h012330, 8'h00);
    // level line 5: W1C ignored, re-request while held
    add_w(8'h10, 8'h20, 8'h20, 0, 24'h012330);
    add_w(8'h11, 8'h20, 8'h20, 1, 24'h012350);
    add_r(8'h11, 8'h20, 0, 1, 24'h012350, 8'h20);
    add_r(8'h11, 8'h20, 1, 0, 24'h012350, 8'h20);
    add_r(8'h15, 8'h20, 0, 0, 24'h012350, 8'h00);
    add_r(8'h15, 8'h20, 0, 1, 24'h012350, 8'h85);
    add_r(8'h11, 8'h00, 1, 0, 24'h012350, 8'h00);
    add_r(8'h15, 8'h00, 0, 0, 24'h012350, 8'h00);
    add_r(8'h15, 8'h00, 0, 0, 24'h012350, 8'h00);
    // edge set beats W1C in the same cycle
    add_w(8'h10, 8'h00, 8'h00, 0, 24'h012350);
    add_w(8'h11, 8'h02, 8'h02, 0, 24'h012350);
    add_r(8'h11, 8'h00, 0, 0, 24'h012350, 8'h02);
    add_w(8'h11, 8'h02, 8'h00, 0, 24'h012350);
    add_r(8'h11, 8'h00, 0, 0, 24'h012350, 8'h00);
    // software interrupt register
    add_w(8'h16, 8'hF1, 8'h00, 0, 24'h012350);
    add_r(8'h11, 8'h00, 0, 0, 24'h012350, swi_ip);
    add_r(8'h16, 8'h00, 0, 0, 24'h012350, 8'h00);
    add_w(8'h11, 8'hFF, 8'h00, 0, 24'h012350);
    add_r(8'h11, 8'h00, 0, 0, 24'h012350, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].irq, tbl[i].isp, tbl[i].we, tbl[i].a, tbl[i].wd);
      chk($sformatf("tbl%0d_int", i), int_o, tbl[i].eint);
      chk($sformatf("tbl%0d_ivec", i), ivec_addr_o, tbl[i].eivec);
      chk($sformatf("tbl%0d_rd", i), xcr_rdata, tbl[i].erd);
    end

    // GEN cleared while requesting: INT held until acknowledged, then no new request
    cyc(8'h01, 0, 1, 8'h10, 8'h01);
    cyc(8'h00, 0, 1, 8'h17, 8'h00); chk("gen_req_int", int_o, 1'b1);
    chk("gen_req_ivec", ivec_addr_o, 24'h012300);
    cyc(8'h00, 0, 0, 8'h17, 8'h00); chk("gen_held_int", int_o, 1'b1);
    chk("gen_ctrl_rd", xcr_rdata, 8'h00);
    cyc(8'h00, 1, 0, 8'h15, 8'h00); chk("gen_ack_int", int_o, 1'b0);
    chk("gen_svc_cur", xcr_rdata, 8'h80);
    cyc(8'h00, 0, 0, 8'h15, 8'h00); chk("gen_idle_cur", xcr_rdata, 8'h00);
    cyc(8'h01, 0, 0, 8'h11, 8'h00); chk("gen_off_ip", xcr_rdata, 8'h01);
    cyc(8'h00, 0, 0, 8'h15, 8'h00); chk("gen_off_int", int_o, 1'b0);
    cyc(8'h00, 0, 1, 8'h17, 8'h01); chk("gen_on_int0", int_o, 1'b0);
    cyc(8'h00, 0, 0, 8'h15, 8'h00); chk("gen_on_int1", int_o, 1'b1);
    chk("gen_on_cur", xcr_rdata, 8'h80);
    cyc(8'h00, 1, 0, 8'h15, 8'h00); chk("svc_int", int_o, 1'b0);

    // reset while in service
    rst = 1'b1;
    cyc(8'h00, 1, 0, 8'h10, 8'h00);
    chk("rst_svc_int", int_o, 1'b0);
    chk("rst_svc_ivec", ivec_addr_o, 24'h000100);
    chk("rst_svc_ie", xcr_rdata, 8'h00);
    rst = 1'b0;
    cyc(8'h00, 0, 0, 8'h11, 8'h00); chk("rst_svc_ip", xcr_rdata, 8'h00);
    cyc(8'h00, 0, 0, 8'h15, 8'h00); chk("rst_svc_cur", xcr_rdata, 8'h00);
    cyc(8'h00, 0, 0, 8'h14, 8'h00); chk("rst_svc_vb2", xcr_rdata, 8'h00);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) != 0) irq_i = 8'($urandom);
      in_isp_i = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      xcr_cs = 1'b1; xcr_we = 1'b0; xcr_wdata = 8'($urandom);
      if (sel < 3) begin
        xcr_we = 1'b1;
        xcr_a  = 8'h10 | 8'($urandom_range(0, 7));
      end else if (sel == 3) begin
        xcr_cs = 1'b0;
        xcr_a  = 8'h11;
      end else if (sel == 4) begin
        xcr_a  = 8'h20 | 8'($urandom_range(0, 7));
      end else begin
        xcr_a  = 8'h10 | 8'($urandom_range(0, 7));
      end
      tick();
      chk("rnd_int", int_o, m_int);
      chk("rnd_ivec", ivec_addr_o, m_ivec);
      chk("rnd_rd", xcr_rdata, model_read());
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
